// File: rtl/blk2s_pkg.sv
// Shared definitions for the BLAKE2s return path: default sizes, FSM state
// encoding and a mod-256 byte-sum helper.
package blk2s_pkg;

  localparam int OUTPUT_SIZE_DEF = 32;
  localparam int BPC_DEF         = 4;
  localparam int ITER_NUM_DEF    = 32;
  localparam int SUM_MAX_BYTES   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    SEND = 2'd2
  } state_t;

  // Sum of the lowest n bytes of vec; carries out of bit 7 are dropped.
  function automatic logic [7:0] sum_bytes(input logic [SUM_MAX_BYTES*8-1:0] vec,
                                           input int n);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < SUM_MAX_BYTES; k++) begin
      if (k < n) s = s + vec[k*8 +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/blk2s_byte_adder.sv
// Combinational mod-256 sum of BPC bytes.
module blk2s_byte_adder
  import blk2s_pkg::*;
#(
  parameter int BPC = BPC_DEF
) (
  input  logic [BPC*8-1:0] i_bytes,
  input  logic             i_unused_tie,
  output logic [7:0]       o_sum
);

  logic [SUM_MAX_BYTES*8-1:0] w_vec;
  logic                       w_unused;

  always_comb begin
    w_vec              = '0;
    w_vec[BPC*8-1:0]   = i_bytes;
    o_sum              = sum_bytes(w_vec, BPC);
  end

  assign w_unused = i_unused_tie;

  if (BPC > SUM_MAX_BYTES) begin : g_bpc_check
    $error("blk2s_byte_adder: BPC exceeds SUM_MAX_BYTES");
  end

endmodule

// File: rtl/blk2s_post.sv
// Return path of the FastKDF BLAKE2s loop: sums a held digest into the next
// buffer pointer over several cycles and offers it with the digest downstream.
//
//  state | meaning
//  IDLE  | ready for a digest from BLK2S
//  SUM   | accumulating BYTES_PER_CYCLE digest bytes per cycle
//  SEND  | pointer + digest offered to BLK2S_PRE, waiting for out_rdy
module blk2s_post
  import blk2s_pkg::*;
#(
  parameter int OUTPUT_SIZE     = OUTPUT_SIZE_DEF,
  parameter int BYTES_PER_CYCLE = BPC_DEF,
  parameter int ITER_NUM        = ITER_NUM_DEF,
  localparam int ITER_W         = (ITER_NUM > 1) ? $clog2(ITER_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [OUTPUT_SIZE*8-1:0] prf_output,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [7:0]               buf_ptr_out,
  output logic [OUTPUT_SIZE*8-1:0] prf_output_o,
  output logic [ITER_W-1:0]        iter_cnt,
  output logic                     last_o
);

  localparam int NBEATS = OUTPUT_SIZE / BYTES_PER_CYCLE;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SLICE_W = BYTES_PER_CYCLE * 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITER_NUM - 1);

  if ((OUTPUT_SIZE % BYTES_PER_CYCLE) != 0) begin : g_bpc_check
    $error("blk2s_post: BYTES_PER_CYCLE must divide OUTPUT_SIZE");
  end

  state_t                   r_state;
  logic                     r_in_rdy;
  logic                     r_out_vld;
  logic [7:0]               r_ptr;
  logic [ITER_W-1:0]        r_iter;
  logic                     r_last;
  logic [7:0]               r_accum;
  logic [BEAT_W-1:0]        r_beat;
  logic [OUTPUT_SIZE*8-1:0] r_digest;

  logic                     w_accept;
  logic [SLICE_W-1:0]       w_slice;
  logic [7:0]               w_beat_sum;
  logic [7:0]               w_new_accum;

  assign w_accept    = (r_state == IDLE) && in_vld;
  assign w_new_accum = r_accum + w_beat_sum;

  always_comb begin
    w_slice = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (r_beat == BEAT_W'(b)) w_slice = r_digest[b*SLICE_W +: SLICE_W];
    end
  end

  blk2s_byte_adder #(
    .BPC(BYTES_PER_CYCLE)
  ) u_byte_adder (
    .i_bytes      (w_slice),
    .i_unused_tie (1'b0),
    .o_sum        (w_beat_sum)
  );

  // Data-only register: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_digest <= prf_output;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_ptr     <= '0;
      r_iter    <= '0;
      r_last    <= 1'b0;
      r_accum   <= '0;
      r_beat    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_vld) begin
            r_accum  <= '0;
            r_beat   <= '0;
            r_in_rdy <= 1'b0;
            r_state  <= SUM;
          end
        end
        SUM: begin
          r_accum <= w_new_accum;
          r_beat  <= r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            r_beat    <= '0;
            r_ptr     <= w_new_accum;
            r_out_vld <= 1'b1;
            r_last    <= (r_iter == LAST_ITER);
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (out_rdy) begin
            r_out_vld <= 1'b0;
            r_last    <= 1'b0;
            r_iter    <= r_last ? '0 : r_iter + 1'b1;
            r_in_rdy  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_rdy       = r_in_rdy;
  assign out_vld      = r_out_vld;
  assign buf_ptr_out  = r_ptr;
  assign prf_output_o = r_digest;
  assign iter_cnt     = r_iter;
  assign last_o       = r_last;

endmodule

// File: tb/tb_blk2s_post.sv
// Directed bench for blk2s_post: table of digests with hand-computed pointers
// plus backpressure, mid-sum reset and full-pass iteration sequences.
module tb_blk2s_post;

  logic         clk;
  logic         rst_n;
  logic         in_vld;
  logic         in_rdy;
  logic [255:0] prf_output;
  logic         out_vld;
  logic         out_rdy;
  logic [7:0]   buf_ptr_out;
  logic [255:0] prf_output_o;
  logic [4:0]   iter_cnt;
  logic         last_o;

  int checks;
  int errors;
  int exp_iter;

  typedef struct {
    logic [255:0] digest;
    logic [7:0]   exp_ptr;
  } vec_t;

  vec_t vecs[6];

  blk2s_post dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .prf_output   (prf_output),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .buf_ptr_out  (buf_ptr_out),
    .prf_output_o (prf_output_o),
    .iter_cnt     (iter_cnt),
    .last_o       (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [7:0] b);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[k*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic [255:0] ramp();
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[k*8 +: 8] = 8'(k);
    return v;
  endfunction

  // Offer one digest, check latency/pointer/iteration, hold off out_rdy for
  // `hold` cycles while poking in_vld, then complete the handshake.
  task automatic xfer(input logic [255:0] d, input logic [7:0] exp_ptr, input int hold);
    int n;
    logic exp_last;
    exp_last = (exp_iter == 31);
    @(negedge clk);
    chk("in_rdy_idle", {255'd0, in_rdy}, 256'd1);
    in_vld     = 1'b1;
    prf_output = d;
    out_rdy    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_vld     = 1'b0;
    prf_output = ~d;
    chk("in_rdy_sum", {255'd0, in_rdy}, 256'd0);
    n = 0;
    while (!out_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 256'(n), 256'd8);
    chk("buf_ptr", {248'd0, buf_ptr_out}, {248'd0, exp_ptr});
    chk("prf_out", prf_output_o, d);
    chk("iter_cnt", {251'd0, iter_cnt}, 256'(exp_iter));
    chk("last_o", {255'd0, last_o}, {255'd0, exp_last});
    for (int h = 0; h < hold; h++) begin
      in_vld     = 1'b1;
      prf_output = fill(8'hA5);
      @(negedge clk);
      chk("hold_vld", {255'd0, out_vld}, 256'd1);
      chk("hold_ptr", {248'd0, buf_ptr_out}, {248'd0, exp_ptr});
      chk("hold_prf", prf_output_o, d);
      chk("hold_rdy", {255'd0, in_rdy}, 256'd0);
    end
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
    in_vld  = 1'b0;
    exp_iter = exp_last ? 0 : exp_iter + 1;
    chk("vld_drop", {255'd0, out_vld}, 256'd0);
    chk("rdy_back", {255'd0, in_rdy}, 256'd1);
    chk("last_drop", {255'd0, last_o}, 256'd0);
    chk("iter_next", {251'd0, iter_cnt}, 256'(exp_iter));
    chk("prf_kept", prf_output_o, d);
  endtask

  initial begin
    logic [255:0] d;
    checks     = 0;
    errors     = 0;
    exp_iter   = 0;
    rst_n      = 1'b0;
    in_vld     = 1'b0;
    out_rdy    = 1'b0;
    prf_output = '0;

    vecs[0] = '{fill(8'h00), 8'h00};
    vecs[1] = '{fill(8'h01), 8'h20};
    vecs[2] = '{fill(8'hFF), 8'hE0};
    vecs[3] = '{ramp(),      8'hF0};
    vecs[4] = '{fill(8'h80), 8'h00};
    vecs[5] = '{fill(8'h03), 8'h60};

    repeat (2) @(negedge clk);
    chk("rst_in_rdy", {255'd0, in_rdy}, 256'd1);
    chk("rst_out_vld", {255'd0, out_vld}, 256'd0);
    chk("rst_ptr", {248'd0, buf_ptr_out}, 256'd0);
    chk("rst_iter", {251'd0, iter_cnt}, 256'd0);
    chk("rst_last", {255'd0, last_o}, 256'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) xfer(vecs[i].digest, vecs[i].exp_ptr, 0);

    xfer(fill(8'h01), 8'h20, 5);

    // Reset during the 4th SUM cycle; iter_cnt is 7 and buf_ptr_out 0x20 here.
    @(negedge clk);
    in_vld     = 1'b1;
    prf_output = fill(8'h11);
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_rdy", {255'd0, in_rdy}, 256'd1);
    chk("mid_rst_out_vld", {255'd0, out_vld}, 256'd0);
    chk("mid_rst_ptr", {248'd0, buf_ptr_out}, 256'd0);
    chk("mid_rst_iter", {251'd0, iter_cnt}, 256'd0);
    chk("mid_rst_last", {255'd0, last_o}, 256'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_iter = 0;
    xfer(ramp(), 8'hF0, 0);

    // Complete the pass and start the next: byte0=i, byte31=3 -> ptr i+3.
    for (int i = 0; i < 32; i++) begin
      d = '0;
      d[7:0]     = 8'(i);
      d[255:248] = 8'h03;
      xfer(d, 8'(i + 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
